fetch_queue_mw: RTL and testbench

- Parametrised multi-wide instruction fetch queue between the i-cache/predecode front end and the dual/multi decoders.
- Accepts up to FETCH_W fetch slots per cycle with an arbitrary valid mask and compacts them into program order.
- Presents the oldest ISSUE_W entries as a contiguous, in-order window and retires a variable count per cycle.
- Generalises the fixed 2-in/2-out fetch buffer with configurable widths and depth, an occupancy count, a configurable almost-full slack and a sticky overflow flag.

---
 rtl/fetch_queue_mw_pkg.sv | 28 ++
 rtl/fetch_queue_mw_if.sv | 30 +++
 rtl/fetch_queue_mw_fq_compact.sv | 28 ++
 rtl/fetch_queue_mw.sv | 109 ++++++++++
 tb/tb_fetch_queue_mw.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_mw_pkg.sv
// Shared definitions for the multi-wide fetch queue: payload layout and the
// NOP entry that downstream decoders substitute for an empty slot.
package fetch_queue_mw_pkg;

  localparam int FQ_ENTRY_W = 136;
  localparam int FQ_DEPTH   = 16;
  localparam int FQ_FETCH_W = 2;
  localparam int FQ_ISSUE_W = 2;
  localparam int FQ_SLACK   = 4;

  // Payload field layout, LSB first: inst, pc, pc_next, exception, badv, unknown.
  localparam int FQ_INST_LSB    = 0;
  localparam int FQ_INST_W      = 32;
  localparam int FQ_PC_LSB      = 32;
  localparam int FQ_PC_W        = 32;
  localparam int FQ_PC_NEXT_LSB = 64;
  localparam int FQ_PC_NEXT_W   = 32;
  localparam int FQ_EXC_LSB     = 96;
  localparam int FQ_EXC_W       = 7;
  localparam int FQ_BADV_LSB    = 103;
  localparam int FQ_BADV_W      = 32;
  localparam int FQ_UNKNOWN_LSB = 135;

  // addi.w r0, r0, 0 -- the canonical NOP encoding.
  localparam logic [FQ_INST_W-1:0]  FQ_NOP_INST  = 32'h0280_0000;
  localparam logic [FQ_ENTRY_W-1:0] FQ_NOP_ENTRY = {{(FQ_ENTRY_W-FQ_INST_W){1'b0}}, FQ_NOP_INST};

endpackage

// File: rtl/fetch_queue_mw_if.sv
// Front-end / decoder facing bundle of the fetch queue.
interface fetch_queue_mw_if #(
  parameter int ENTRY_W = 136,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 16
);
  localparam int POPW = $clog2(ISSUE_W + 1);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic                       flush;
  logic [FETCH_W-1:0]         in_valid;
  logic [FETCH_W*ENTRY_W-1:0] in_data;
  logic [POPW-1:0]            pop_num;
  logic                       almost_full;
  logic [ISSUE_W-1:0]         out_valid;
  logic [ISSUE_W*ENTRY_W-1:0] out_data;
  logic [CNTW-1:0]            count;
  logic                       overflow;

  modport master (
    output flush, in_valid, in_data, pop_num,
    input  almost_full, out_valid, out_data, count, overflow
  );

  modport slave (
    input  flush, in_valid, in_data, pop_num,
    output almost_full, out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/fetch_queue_mw_fq_compact.sv
// Prefix-count compactor: each valid lane learns how many valid lanes
// precede it, which is its write offset from the queue tail.
module fq_compact #(
  parameter int FETCH_W = 2,
  parameter int OFFW    = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]           i_valid,
  output logic [FETCH_W-1:0][OFFW-1:0] o_off,
  output logic [FETCH_W-1:0]           o_we,
  output logic [OFFW-1:0]              o_n_in
);

  logic [OFFW-1:0] w_acc;

  // Running count of valid lanes below each lane, lane 0 oldest.
  always_comb begin
    w_acc = {OFFW{1'b0}};
    o_off = '0;
    o_we  = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      o_off[i] = w_acc;
      o_we[i]  = i_valid[i];
      w_acc    = w_acc + OFFW'(i_valid[i]);
    end
    o_n_in = w_acc;
  end

endmodule

// File: rtl/fetch_queue_mw.sv
// Multi-wide in-order fetch queue: compacts a holey fetch group into the
// ring, exposes the oldest ISSUE_W entries and retires a variable count.
module fetch_queue_mw
  import fetch_queue_mw_pkg::*;
#(
  parameter int ENTRY_W = FQ_ENTRY_W,
  parameter int DEPTH   = FQ_DEPTH,
  parameter int FETCH_W = FQ_FETCH_W,
  parameter int ISSUE_W = FQ_ISSUE_W,
  parameter int SLACK   = FQ_SLACK
) (
  input  logic            clk,
  input  logic            rst,
  fetch_queue_mw_if.slave bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int OFFW = $clog2(FETCH_W + 1);

  logic [ENTRY_W-1:0]           r_mem [DEPTH];
  logic [PW-1:0]                r_head;
  logic [PW-1:0]                r_tail;
  logic [CNTW-1:0]              r_count;
  logic                         r_overflow;

  logic [FETCH_W-1:0][OFFW-1:0] w_off;
  logic [FETCH_W-1:0]           w_we;
  logic [OFFW-1:0]              w_n_in;
  logic [CNTW-1:0]              w_n_in_c;
  logic [CNTW-1:0]              w_free;
  logic [CNTW-1:0]              w_k;
  logic [CNTW-1:0]              w_pop_c;
  logic [CNTW-1:0]              w_eff_pop;
  logic                         w_accept;
  logic [ISSUE_W-1:0]           w_out_valid;
  logic [ISSUE_W*ENTRY_W-1:0]   w_out_data;

  fq_compact #(
    .FETCH_W (FETCH_W),
    .OFFW    (OFFW)
  ) u_compact (
    .i_valid (bus.in_valid),
    .o_off   (w_off),
    .o_we    (w_we),
    .o_n_in  (w_n_in)
  );

  // Acceptance uses the registered count only; pops this cycle do not free space.
  always_comb begin
    w_n_in_c  = CNTW'(w_n_in);
    w_free    = CNTW'(DEPTH) - r_count;
    w_accept  = (w_n_in_c <= w_free);
    w_k       = (r_count < CNTW'(ISSUE_W)) ? r_count : CNTW'(ISSUE_W);
    w_pop_c   = CNTW'(bus.pop_num);
    w_eff_pop = (w_pop_c > w_k) ? w_k : w_pop_c;
  end

  // Issue window: oldest entries in order, invalid lanes forced to zero.
  always_comb begin
    w_out_valid = '0;
    w_out_data  = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      if (CNTW'(l) < r_count) begin
        w_out_valid[l]                   = 1'b1;
        w_out_data[l*ENTRY_W +: ENTRY_W] = r_mem[r_head + PW'(l)];
      end else begin
        w_out_valid[l]                   = 1'b0;
        w_out_data[l*ENTRY_W +: ENTRY_W] = {ENTRY_W{1'b0}};
      end
    end
  end

  // Pointer, occupancy and sticky overflow update; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_head     <= {PW{1'b0}};
      r_tail     <= {PW{1'b0}};
      r_count    <= {CNTW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tail <= r_tail + PW'(w_n_in);
      end else begin
        r_overflow <= 1'b1;
      end
      r_head  <= r_head + PW'(w_eff_pop);
      r_count <= r_count + (w_accept ? w_n_in_c : {CNTW{1'b0}}) - w_eff_pop;
    end
  end

  // Payload storage, not reset; each valid lane lands at tail + its offset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && w_accept) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (w_we[i]) begin
          r_mem[r_tail + PW'(w_off[i])] <= bus.in_data[i*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_out_data;
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.almost_full = (w_free < CNTW'(SLACK));

endmodule

// File: tb/tb_fetch_queue_mw.sv
// Directed bench for fetch_queue_mw with default parameters
// (DEPTH=16, FETCH_W=2, ISSUE_W=2, SLACK=4).
module tb_fetch_queue_mw;
  import fetch_queue_mw_pkg::*;

  localparam int EW = FQ_ENTRY_W;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fetch_queue_mw_if #(.ENTRY_W(EW), .FETCH_W(2), .ISSUE_W(2), .DEPTH(16)) bus ();

  fetch_queue_mw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  pop;
    logic        fl;
    logic [4:0]  cnt;
    logic [1:0]  ov;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        af;
    logic        of;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [EW-1:0] mk(input logic [31:0] inst);
    logic [EW-1:0] e;
    e          = '0;
    e[31:0]    = inst;
    e[63:32]   = inst + 32'h0000_1000;
    e[95:64]   = inst + 32'h0000_1004;
    e[134:103] = ~inst;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] pop, input logic fl);
    bus.in_valid = vld;
    bus.in_data  = {mk(i1), mk(i0)};
    bus.pop_num  = pop;
    bus.flush    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string nm, input logic [4:0] cnt, input logic [1:0] ov,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic af, input logic of);
    chk({nm, ".count"}, EW'(bus.count), EW'(cnt));
    chk({nm, ".out_valid"}, EW'(bus.out_valid), EW'(ov));
    chk({nm, ".lane0"}, bus.out_data[EW-1:0], ov[0] ? mk(d0) : {EW{1'b0}});
    chk({nm, ".lane1"}, bus.out_data[2*EW-1:EW], ov[1] ? mk(d1) : {EW{1'b0}});
    chk({nm, ".almost_full"}, EW'(bus.almost_full), EW'(af));
    chk({nm, ".overflow"}, EW'(bus.overflow), EW'(of));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    tbl[0] = '{2'b10, 32'hDEAD_0000, 32'h0280_0000, 2'd0, 1'b0, 5'd1, 2'b01, 32'h0280_0000, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 32'h0000_0A0A, 32'h0000_0B0B, 2'd0, 1'b0, 5'd3, 2'b11, 32'h0280_0000, 32'h0000_0A0A, 1'b0, 1'b0};
    tbl[2] = '{2'b01, 32'h0000_0C0C, 32'hDEAD_0001, 2'd2, 1'b0, 5'd2, 2'b11, 32'h0000_0B0B, 32'h0000_0C0C, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 5'd1, 2'b01, 32'h0000_0C0C, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[5] = '{2'b00, 32'h0, 32'h0, 2'd3, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[6] = '{2'b11, 32'h0000_0D0D, 32'h0000_0E0E, 2'd3, 1'b0, 5'd2, 2'b11, 32'h0000_0D0D, 32'h0000_0E0E, 1'b0, 1'b0};
    tbl[7] = '{2'b11, 32'h0000_0F0F, 32'h0000_1111, 2'd2, 1'b1, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0};

    // Reset held two cycles with both lanes valid.
    rst = 1'b1;
    drive(2'b11, 32'h5555_0000, 32'h5555_0001, 2'd0, 1'b0);
    step();
    step();
    check_state("reset", 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
    step();
    check_state("post_reset", 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

    // Table: compaction, pops, clamp, empty pop, flush.
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].vld, tbl[v].i0, tbl[v].i1, tbl[v].pop, tbl[v].fl);
      step();
      check_state($sformatf("vec%0d", v), tbl[v].cnt, tbl[v].ov, tbl[v].d0, tbl[v].d1, tbl[v].af, tbl[v].of);
    end

    // Fill 2 per cycle up to full; almost_full from count 14.
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'h0000_1000 + 32'(2*i), 32'h0000_1001 + 32'(2*i), 2'd0, 1'b0);
      step();
      chk($sformatf("fill%0d.count", i), EW'(bus.count), EW'(2*i + 2));
      chk($sformatf("fill%0d.almost_full", i), EW'(bus.almost_full), EW'((2*i + 2) >= 14));
    end
    drive(2'b11, 32'h0000_BAD0, 32'h0000_BAD1, 2'd0, 1'b0);
    step();
    check_state("drop", 5'd16, 2'b11, 32'h0000_1000, 32'h0000_1001, 1'b1, 1'b1);
    // Push with pop on a full queue: push still dropped.
    drive(2'b01, 32'h0000_BAD2, 32'h0, 2'd2, 1'b0);
    step();
    check_state("full_push_pop", 5'd14, 2'b11, 32'h0000_1002, 32'h0000_1003, 1'b1, 1'b1);
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
    step();
    check_state("sticky", 5'd14, 2'b11, 32'h0000_1002, 32'h0000_1003, 1'b1, 1'b1);
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
    step();
    check_state("flush_clear", 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

    // Rotate head to 15 with matched single push/pop, then drain.
    for (int i = 0; i < 15; i++) begin
      drive(2'b01, 32'h0000_2000 + 32'(i), 32'h0, 2'd1, 1'b0);
      step();
    end
    chk("rotate.count", EW'(bus.count), EW'(1));
    chk("rotate.lane0", bus.out_data[EW-1:0], mk(32'h0000_200E));
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    step();
    chk("rotate_drain.count", EW'(bus.count), EW'(0));
    drive(2'b11, 32'h0000_0X0X ^ 32'h0, 32'h0, 2'd0, 1'b0);
    drive(2'b11, 32'hCAFE_0015, 32'hCAFE_0000, 2'd0, 1'b0);
    step();
    check_state("wrap", 5'd2, 2'b11, 32'hCAFE_0015, 32'hCAFE_0000, 1'b0, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    step();
    check_state("wrap_pop1", 5'd1, 2'b01, 32'hCAFE_0000, 32'h0, 1'b0, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    step();

    // Flush priority over push and pop with six entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h0000_3000 + 32'(2*i), 32'h0000_3001 + 32'(2*i), 2'd0, 1'b0);
      step();
    end
    check_state("pre_flush", 5'd6, 2'b11, 32'h0000_3000, 32'h0000_3001, 1'b0, 1'b0);
    drive(2'b11, 32'h0000_4000, 32'h0000_4001, 2'd2, 1'b1);
    step();
    check_state("flush_prio", 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
    step();
    check_state("after_flush", 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
